// File: rtl/triangle_monitor_pkg.sv
// Shared types and constants for the triangle-counter receive-side monitor.
package triangle_mon_pkg;

    typedef enum logic [1:0] {
        HUNT,
        ACQ,
        LOCKED
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_SEQ  = 2'd1;
    localparam logic [1:0] ERR_DIR  = 2'd2;
    localparam logic [1:0] ERR_WIN  = 2'd3;

endpackage

// File: rtl/triangle_monitor_if.sv
// Observed generator signals in, monitor status out; master drives samples, slave is the monitor.
interface triangle_monitor_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CW    = 16
);
    logic             en;
    logic [WIDTH-1:0] cnt_in;
    logic             flip_in;
    logic             tick_in;
    logic             locked;
    logic             err_pulse;
    logic [1:0]       err_code;
    logic             trough_pulse;
    logic [CW-1:0]    period_count;
    logic [CW-1:0]    err_count;

    modport master (
        output en, cnt_in, flip_in, tick_in,
        input  locked, err_pulse, err_code, trough_pulse, period_count, err_count
    );

    modport slave (
        input  en, cnt_in, flip_in, tick_in,
        output locked, err_pulse, err_code, trough_pulse, period_count, err_count
    );
endinterface

// File: rtl/tri_predict.sv
// Next legal (count, flip) of an up/down triangle counter given the previous sample.
module tri_predict #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] pc,
    input  logic             pf,
    output logic [WIDTH-1:0] exp_cnt,
    output logic             exp_flip
);
    localparam logic [WIDTH-1:0] MAXV = '1;

    always_comb begin
        exp_cnt  = pc + 1'b1;
        exp_flip = 1'b0;
        if (!pf && pc == MAXV) begin
            exp_cnt  = MAXV - 1'b1;
            exp_flip = 1'b1;
        end else if (pf && pc == '0) begin
            exp_cnt  = WIDTH'(1);
            exp_flip = 1'b0;
        end else if (pf) begin
            exp_cnt  = pc - 1'b1;
            exp_flip = 1'b1;
        end
    end
endmodule

// File: rtl/triangle_monitor.sv
// Lock-acquiring checker for a triangle counter stream: sequence, direction and window violations.
module triangle_monitor
    import triangle_mon_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned WIN_LO   = 6,
    parameter int unsigned WIN_HI   = 9,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned CW       = 16
) (
    input  logic clk,
    input  logic reset,
    triangle_monitor_if.slave mon
);
    localparam logic [CW-1:0] CMAX = '1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pf_q, pf_d;
    logic [3:0]       good_q, good_d;
    logic             locked_q, err_pulse_q, err_pulse_d, trough_q, trough_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [CW-1:0]    period_q, period_d, errcnt_q, errcnt_d;

    logic [WIDTH-1:0] exp_cnt;
    logic             exp_flip;
    logic             tick_exp;
    logic [1:0]       code;
    logic [31:0]      cnt_ext;

    tri_predict #(.WIDTH(WIDTH)) u_predict (
        .pc       (pc_q),
        .pf       (pf_q),
        .exp_cnt  (exp_cnt),
        .exp_flip (exp_flip)
    );

    // An inverted window (WIN_LO > WIN_HI) naturally yields tick_exp = 0.
    assign cnt_ext  = 32'(mon.cnt_in);
    assign tick_exp = (cnt_ext >= WIN_LO) && (cnt_ext <= WIN_HI);

    always_comb begin
        code = ERR_NONE;
        if (mon.cnt_in != exp_cnt)         code = ERR_SEQ;
        else if (mon.flip_in != exp_flip)  code = ERR_DIR;
        else if (mon.tick_in != tick_exp)  code = ERR_WIN;
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pf_d        = pf_q;
        good_d      = good_q;
        err_pulse_d = 1'b0;
        trough_d    = 1'b0;
        err_code_d  = err_code_q;
        period_d    = period_q;
        errcnt_d    = errcnt_q;
        if (!mon.en) begin
            state_d = HUNT;
            good_d  = '0;
        end else begin
            // Always re-sync on the observed sample, matched or not.
            pc_d = mon.cnt_in;
            pf_d = mon.flip_in;
            unique case (state_q)
                HUNT: begin
                    state_d = ACQ;
                    good_d  = '0;
                end
                ACQ: begin
                    if (code == ERR_NONE) begin
                        good_d = good_q + 4'd1;
                        if (32'(good_d) >= LOCK_CNT) state_d = LOCKED;
                    end else begin
                        good_d = '0;
                    end
                end
                LOCKED: begin
                    if (code != ERR_NONE) begin
                        err_pulse_d = 1'b1;
                        err_code_d  = code;
                        if (errcnt_q != CMAX) errcnt_d = errcnt_q + 1'b1;
                        good_d  = '0;
                        state_d = ACQ;
                    end else if (mon.cnt_in == '0 && mon.flip_in) begin
                        trough_d = 1'b1;
                        if (period_q != CMAX) period_d = period_q + 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= HUNT;
            pc_q        <= '0;
            pf_q        <= 1'b0;
            good_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            trough_q    <= 1'b0;
            err_code_q  <= ERR_NONE;
            period_q    <= '0;
            errcnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pf_q        <= pf_d;
            good_q      <= good_d;
            locked_q    <= (state_d == LOCKED);
            err_pulse_q <= err_pulse_d;
            trough_q    <= trough_d;
            err_code_q  <= err_code_d;
            period_q    <= period_d;
            errcnt_q    <= errcnt_d;
        end
    end

    assign mon.locked       = locked_q;
    assign mon.err_pulse    = err_pulse_q;
    assign mon.err_code     = err_code_q;
    assign mon.trough_pulse = trough_q;
    assign mon.period_count = period_q;
    assign mon.err_count    = errcnt_q;
endmodule

// File: doc/triangle_monitor.md
Name: triangle_monitor

Overview:
- Receive-side checker for the 4-bit up/down triangle counter and its companion signals: count value, direction flag `flip`, and window tick.
- Samples the generator's outputs every enabled cycle and predicts the next legal sample from the previous one.
- Acquires lock, then reports sequence, direction and window violations and counts completed periods.
- Sits on the consumer side of the counter, in the same clock domain.

Parameters:
- WIDTH, 4, counter width; max value MAXV = 2^WIDTH-1.
- WIN_LO, 6, lowest count with tick expected high.
- WIN_HI, 9, highest count with tick expected high.
- LOCK_CNT, 4, consecutive correct predictions needed to enter LOCKED (1..15).
- CW, 16, width of the saturating period and error counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  monitor enable; low forces HUNT.
- cnt_in  in  WIDTH  observed counter value.
- flip_in  in  1  observed direction flag (1 = counting down).
- tick_in  in  1  observed window tick.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse on a violation while LOCKED.
- err_code  out  2  0 none, 1 sequence, 2 direction, 3 window; holds the last error.
- trough_pulse  out  1  one-cycle pulse per completed period while LOCKED.
- period_count  out  CW  saturating count of trough_pulse events.
- err_count  out  CW  saturating count of err_pulse events.

Behaviour:
- Reset (async, reset=0) sets:
  - state=HUNT, prev sample=0, good=0.
  - locked=0, err_pulse=0, trough_pulse=0, err_code=0, period_count=0, err_count=0.
- All outputs are registered. An event on the sample presented in cycle N appears on the outputs after edge N+1 (1-cycle latency).
- Prediction from the previous sample (pc, pf):
  - pf=0, pc=MAXV: expect (MAXV-1, 1).
  - pf=1, pc=0: expect (1, 0).
  - pf=0 otherwise: expect (pc+1, 0).
  - pf=1 otherwise: expect (pc-1, 1).
  - Legal stream period is 2*MAXV = 30 cycles: 0,1..15 with flip=0, then 14..0 with flip=1.
- Checks on the current sample, in priority order:
  - sequence: cnt_in != expected count.
  - direction: flip_in != expected flip.
  - window: tick_in != (WIN_LO <= cnt_in <= WIN_HI).
  - The highest-priority failing check sets the code; only one code is reported per cycle.
- The prev sample is updated with the actual input on every enabled cycle, matched or not, so the monitor re-syncs.
- States:
  - HUNT: capture sample, go to ACQ with good=0. No checks.
  - ACQ: pass -> good++; when good reaches LOCK_CNT, go to LOCKED. Fail -> good=0, stay in ACQ, no err_pulse, counters unchanged.
  - LOCKED: pass -> stay. Fail -> err_pulse=1, err_code=code, err_count++, good=0, go to ACQ (locked drops the same edge).
- Trough: in LOCKED with a passing sample where cnt_in=0 and flip_in=1 -> trough_pulse=1 and period_count++.
- Counters saturate at 2^CW-1; they never wrap.
- en=0:
  - next state is HUNT, good=0, locked=0, pulses 0.
  - period_count, err_count and err_code hold.
  - On re-enable, the first sample is capture-only.
- Reset asserted mid-operation clears immediately, independent of clk.
- Window parameters with WIN_LO > WIN_HI mean tick is expected always low.
- err_code is cleared only by reset.

Decomposition:
- Package triangle_mon_pkg holds:
  - state enum {HUNT, ACQ, LOCKED}.
  - err code constants ERR_NONE/ERR_SEQ/ERR_DIR/ERR_WIN.
- Sub-module tri_predict: purely combinational, (pc, pf) -> (expected count, expected flip), parameterised by WIDTH.
- The top level holds the state machine, checks and counters.

Test Plan:
- Reset release, legal stream from (0,0):
  - locked=1 after LOCK_CNT+1 = 5 enabled samples.
  - trough_pulse once per 30 cycles.
  - period_count=3 after 3 full periods.
  - err_count=0.
- Locked, then one sample at cnt_in=8 forced to 10:
  - err_pulse one cycle, err_code=1, err_count=1, locked falls.
  - Relock after 4 more good samples (the monitor re-syncs on 10 then 11).
- Locked, flip_in forced 1 at cnt_in=5 on an up-count: err_code=2, err_count increments.
- Locked, tick_in=0 at cnt_in=7: err_code=3. Tick high at cnt_in=10 also gives err_code=3.
- Combined fault, cnt=9 expected but (cnt 3, flip 1, tick 1) presented: err_code=1 (sequence priority), a single err_pulse.
- Control cases:
  - en dropped for 5 cycles mid-period: locked=0 next edge, counters hold.
  - Re-enable then relock in 5 samples.
  - Async reset asserted between edges clears all outputs immediately.
  - Saturation checked with CW=2: period_count sticks at 3.
